// File: rtl/amb_hakem_pkg.sv
// ---------------------------------------------------------------------------
// amb_hakem_pkg
// Shared definitions for the amb_hakem arbiter/sequencer slice:
//   - UOP_AMB_BIT : micro-op code width of the shared amb ALU
//   - durum_t     : controller states BOSTA / MESGUL / CIKIS
//   - ISTEKCI_0/1 : requester ids carried with each result
//   - UOP_*       : a few ALU micro-op codes used around the arbiter
// ---------------------------------------------------------------------------
package amb_hakem_pkg;

    localparam int UOP_AMB_BIT = 5;

    typedef enum logic [1:0] {
        BOSTA  = 2'b00,   // idle, can accept a request
        MESGUL = 2'b01,   // ALU operation in flight
        CIKIS  = 2'b10    // result held on the output port
    } durum_t;

    localparam logic ISTEKCI_0 = 1'b0;
    localparam logic ISTEKCI_1 = 1'b1;

    localparam logic [UOP_AMB_BIT-1:0] UOP_ADD  = 5'd0;
    localparam logic [UOP_AMB_BIT-1:0] UOP_SUB  = 5'd1;
    localparam logic [UOP_AMB_BIT-1:0] UOP_MUL  = 5'd8;
    localparam logic [UOP_AMB_BIT-1:0] UOP_DIVU = 5'd12;
    localparam logic [UOP_AMB_BIT-1:0] UOP_REMU = 5'd13;
    localparam logic [UOP_AMB_BIT-1:0] UOP_CNTZ = 5'd16;
    localparam logic [UOP_AMB_BIT-1:0] UOP_CNTP = 5'd17;

endpackage

// File: rtl/amb_hakem_rr_hakem2.sv
// ---------------------------------------------------------------------------
// rr_hakem2
// Combinational two-way round-robin grant.
//   istek0, istek1 : request valid bits
//   son            : id of the requester granted last
//   izin0, izin1   : one-hot (or zero) grant
// With both requesting, the requester that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_hakem2
    import amb_hakem_pkg::*;
(
    input  logic istek0,
    input  logic istek1,
    input  logic son,
    output logic izin0,
    output logic izin1
);

    always_comb begin
        izin0 = istek0 & (!istek1 | (son == ISTEKCI_1));
        izin1 = istek1 & (!istek0 | (son == ISTEKCI_0));
    end

endmodule

// File: rtl/amb_hakem.sv
// ---------------------------------------------------------------------------
// amb_hakem
// Two-requester arbiter and sequencer in front of the shared amb ALU.
// Accepts an operation from issue port 0 or 1 (round-robin), latches code,
// operands, tag and requester id, holds amb_kod_gecerli_o high with stable
// operands until the ALU answers, then presents the tagged result.
//
// Optional feature: define AMB_HAKEM_ZAMAN_ASIMI_EN to enable a watchdog
// that aborts an ALU operation after ZAMAN_SINIR busy cycles, returning
// all-ones with sonuc_hata_o = 1.
//
// Ports:
//   clk_i, rst_i (sync, active-high), temizle_i (flush)
//   istek{0,1}_gecerli_i/_hazir_o/_kod_i/_islec1_i/_islec2_i/_etiket_i
//   amb_kod_o, amb_kod_gecerli_o, amb_islec1_o, amb_islec2_o -> ALU
//   amb_sonuc_i, amb_gecerli_i                               <- ALU
//   sonuc_gecerli_o, sonuc_hazir_i, sonuc_o, sonuc_istekci_o,
//   sonuc_etiket_o, sonuc_hata_o                             -> consumer
//   durum_o : current controller state (debug)
//
// Handshakes: every port is valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1; a producer keeps valid and its
// data stable until the transfer; ready may depend combinationally on
// valid. Here ready of the issue ports also depends on sonuc_hazir_i so
// that a new request can be taken in the cycle the result leaves.
// ---------------------------------------------------------------------------
module amb_hakem
    import amb_hakem_pkg::*;
#(
    parameter int VERI_BIT    = 32,
    parameter int UOP_BIT     = UOP_AMB_BIT,
    parameter int ETIKET_BIT  = 4,
    parameter int ZAMAN_SINIR = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  temizle_i,

    input  logic                  istek0_gecerli_i,
    output logic                  istek0_hazir_o,
    input  logic [UOP_BIT-1:0]    istek0_kod_i,
    input  logic [VERI_BIT-1:0]   istek0_islec1_i,
    input  logic [VERI_BIT-1:0]   istek0_islec2_i,
    input  logic [ETIKET_BIT-1:0] istek0_etiket_i,

    input  logic                  istek1_gecerli_i,
    output logic                  istek1_hazir_o,
    input  logic [UOP_BIT-1:0]    istek1_kod_i,
    input  logic [VERI_BIT-1:0]   istek1_islec1_i,
    input  logic [VERI_BIT-1:0]   istek1_islec2_i,
    input  logic [ETIKET_BIT-1:0] istek1_etiket_i,

    output logic [UOP_BIT-1:0]    amb_kod_o,
    output logic                  amb_kod_gecerli_o,
    output logic [VERI_BIT-1:0]   amb_islec1_o,
    output logic [VERI_BIT-1:0]   amb_islec2_o,
    input  logic [VERI_BIT-1:0]   amb_sonuc_i,
    input  logic                  amb_gecerli_i,

    output logic                  sonuc_gecerli_o,
    input  logic                  sonuc_hazir_i,
    output logic [VERI_BIT-1:0]   sonuc_o,
    output logic                  sonuc_istekci_o,
    output logic [ETIKET_BIT-1:0] sonuc_etiket_o,
    output logic                  sonuc_hata_o,

    output logic [1:0]            durum_o
);

    if (ZAMAN_SINIR < 1) begin : g_parametre_kontrol
        $error("amb_hakem: ZAMAN_SINIR must be at least 1");
    end

    durum_t                durum_q, durum_d;
    logic                  son_q;
    logic [UOP_BIT-1:0]    kod_q;
    logic [VERI_BIT-1:0]   islec1_q, islec2_q;
    logic [ETIKET_BIT-1:0] etiket_q;
    logic                  istekci_q;
    logic [VERI_BIT-1:0]   sonuc_q;
    logic [ETIKET_BIT-1:0] sonuc_etiket_q;
    logic                  sonuc_istekci_q;

    logic izin0, izin1;
    logic kabul_acik, kabul, secilen;
    logic sonuc_yukle;
    logic zaman_doldu;

    rr_hakem2 u_rr_hakem2 (
        .istek0 (istek0_gecerli_i),
        .istek1 (istek1_gecerli_i),
        .son    (son_q),
        .izin0  (izin0),
        .izin1  (izin1)
    );

    // -----------------------------------------------------------------------
    // Optional watchdog
    // -----------------------------------------------------------------------
`ifdef AMB_HAKEM_ZAMAN_ASIMI_EN
    localparam int SAYAC_W = $clog2(ZAMAN_SINIR + 1);
    logic [SAYAC_W-1:0] sayac_q;
    logic               hata_q;

    // sayac_q counts completed MESGUL cycles before the current one, so the
    // limit is hit during the ZAMAN_SINIR-th busy cycle.
    assign zaman_doldu  = (durum_q == MESGUL) &&
                          (sayac_q == SAYAC_W'(ZAMAN_SINIR - 1));
    assign sonuc_hata_o = hata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sayac_q <= '0;
            hata_q  <= 1'b0;
        end else begin
            if (durum_d == MESGUL && durum_q != MESGUL) begin
                sayac_q <= '0;
            end else if (durum_q == MESGUL) begin
                sayac_q <= sayac_q + 1'b1;
            end
            if (sonuc_yukle) begin
                hata_q <= !amb_gecerli_i;
            end
        end
    end
`else
    assign zaman_doldu  = 1'b0;
    assign sonuc_hata_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Accept / next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        kabul_acik  = 1'b0;
        kabul       = 1'b0;
        secilen     = ISTEKCI_0;
        sonuc_yukle = 1'b0;
        durum_d     = durum_q;

        // Requests are taken in BOSTA, or in CIKIS when the result leaves
        // in the same cycle; never during reset or flush.
        kabul_acik = !rst_i && !temizle_i &&
                     ((durum_q == BOSTA) ||
                      (durum_q == CIKIS && sonuc_hazir_i));

        istek0_hazir_o = istek0_gecerli_i & izin0 & kabul_acik;
        istek1_hazir_o = istek1_gecerli_i & izin1 & kabul_acik;
        kabul          = istek0_hazir_o | istek1_hazir_o;
        secilen        = istek1_hazir_o ? ISTEKCI_1 : ISTEKCI_0;

        sonuc_yukle = (durum_q == MESGUL) && !temizle_i &&
                      (amb_gecerli_i || zaman_doldu);

        if (temizle_i) begin
            durum_d = BOSTA;
        end else begin
            unique case (durum_q)
                BOSTA: begin
                    if (kabul) durum_d = MESGUL;
                end
                MESGUL: begin
                    if (sonuc_yukle) durum_d = CIKIS;
                end
                CIKIS: begin
                    if (sonuc_hazir_i) durum_d = kabul ? MESGUL : BOSTA;
                end
                default: durum_d = BOSTA;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q         <= BOSTA;
            son_q           <= ISTEKCI_1;
            kod_q           <= '0;
            islec1_q        <= '0;
            islec2_q        <= '0;
            etiket_q        <= '0;
            istekci_q       <= ISTEKCI_0;
            sonuc_q         <= '0;
            sonuc_etiket_q  <= '0;
            sonuc_istekci_q <= ISTEKCI_0;
        end else begin
            durum_q <= durum_d;
            if (kabul) begin
                son_q     <= secilen;
                istekci_q <= secilen;
                kod_q     <= secilen ? istek1_kod_i    : istek0_kod_i;
                islec1_q  <= secilen ? istek1_islec1_i : istek0_islec1_i;
                islec2_q  <= secilen ? istek1_islec2_i : istek0_islec2_i;
                etiket_q  <= secilen ? istek1_etiket_i : istek0_etiket_i;
            end
            // Result registers load only when leaving MESGUL, so they stay
            // constant for the whole time the result waits in CIKIS.
            if (sonuc_yukle) begin
                sonuc_q         <= amb_gecerli_i ? amb_sonuc_i : '1;
                sonuc_etiket_q  <= etiket_q;
                sonuc_istekci_q <= istekci_q;
            end
        end
    end

    // amb_kod_gecerli_o is 0 outside MESGUL, which lets the ALU clear its
    // internal counter/accumulator between two operations.
    assign amb_kod_gecerli_o = (durum_q == MESGUL);
    assign amb_kod_o         = kod_q;
    assign amb_islec1_o      = islec1_q;
    assign amb_islec2_o      = islec2_q;

    assign sonuc_gecerli_o   = (durum_q == CIKIS);
    assign sonuc_o           = sonuc_q;
    assign sonuc_etiket_o    = sonuc_etiket_q;
    assign sonuc_istekci_o   = sonuc_istekci_q;

    assign durum_o           = durum_q;

endmodule

// File: tb/tb_amb_hakem.sv
// ---------------------------------------------------------------------------
// tb_amb_hakem
// Directed bench for amb_hakem with a small behavioural ALU model
// (ADD/SUB: 1 cycle, MUL: 4 cycles, DIVU: 33 cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_amb_hakem;
    import amb_hakem_pkg::*;

    localparam int VW = 32;
    localparam int UW = UOP_AMB_BIT;
    localparam int EW = 4;

    logic          clk;
    logic          rst;
    logic          temizle;
    logic          gecerli0, gecerli1;
    logic          hazir0, hazir1;
    logic [UW-1:0] kod0, kod1;
    logic [VW-1:0] a0, b0, a1, b1;
    logic [EW-1:0] et0, et1;
    logic [UW-1:0] amb_kod;
    logic          amb_kod_gecerli;
    logic [VW-1:0] amb_a, amb_b;
    logic [VW-1:0] amb_sonuc;
    logic          amb_gecerli;
    logic          sonuc_gecerli;
    logic          sonuc_hazir;
    logic [VW-1:0] sonuc;
    logic          sonuc_istekci;
    logic [EW-1:0] sonuc_etiket;
    logic          sonuc_hata;
    logic [1:0]    durum;

    int dogrulama;
    int hata_sayisi;

    // ALU model control
    logic       alu_sessiz;
    logic [7:0] alu_sayac;

    amb_hakem #(
        .VERI_BIT    (VW),
        .UOP_BIT     (UW),
        .ETIKET_BIT  (EW),
        .ZAMAN_SINIR (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .temizle_i         (temizle),
        .istek0_gecerli_i  (gecerli0),
        .istek0_hazir_o    (hazir0),
        .istek0_kod_i      (kod0),
        .istek0_islec1_i   (a0),
        .istek0_islec2_i   (b0),
        .istek0_etiket_i   (et0),
        .istek1_gecerli_i  (gecerli1),
        .istek1_hazir_o    (hazir1),
        .istek1_kod_i      (kod1),
        .istek1_islec1_i   (a1),
        .istek1_islec2_i   (b1),
        .istek1_etiket_i   (et1),
        .amb_kod_o         (amb_kod),
        .amb_kod_gecerli_o (amb_kod_gecerli),
        .amb_islec1_o      (amb_a),
        .amb_islec2_o      (amb_b),
        .amb_sonuc_i       (amb_sonuc),
        .amb_gecerli_i     (amb_gecerli),
        .sonuc_gecerli_o   (sonuc_gecerli),
        .sonuc_hazir_i     (sonuc_hazir),
        .sonuc_o           (sonuc),
        .sonuc_istekci_o   (sonuc_istekci),
        .sonuc_etiket_o    (sonuc_etiket),
        .sonuc_hata_o      (sonuc_hata),
        .durum_o           (durum)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    function automatic int alu_gecikme(input logic [UW-1:0] k);
        if (k == UOP_MUL)  return 4;
        if (k == UOP_DIVU) return 33;
        return 1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || !amb_kod_gecerli) alu_sayac <= '0;
        else                         alu_sayac <= alu_sayac + 8'd1;
    end

    always_comb begin
        amb_sonuc = '0;
        if (amb_kod == UOP_ADD)       amb_sonuc = amb_a + amb_b;
        else if (amb_kod == UOP_SUB)  amb_sonuc = amb_a - amb_b;
        else if (amb_kod == UOP_MUL)  amb_sonuc = amb_a * amb_b;
        else if (amb_kod == UOP_DIVU) amb_sonuc = (amb_b == 0) ? '1 : amb_a / amb_b;
    end

    assign amb_gecerli = amb_kod_gecerli && !alu_sessiz &&
                         (alu_sayac == 8'(alu_gecikme(amb_kod) - 1));

    // ---------------- driver tasks ----------------
    task automatic bosta_girisler();
        temizle     = 1'b0;
        gecerli0    = 1'b0;
        gecerli1    = 1'b0;
        sonuc_hazir = 1'b0;
    endtask

    task automatic sur0(input logic [UW-1:0] k, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [EW-1:0] e);
        kod0 = k; a0 = a; b0 = b; et0 = e;
    endtask

    task automatic sur1(input logic [UW-1:0] k, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [EW-1:0] e);
        kod1 = k; a1 = a; b1 = b; et1 = e;
    endtask

    // Presents a request on port 0 for one cycle; returns at the next
    // falling edge with the request withdrawn.
    task automatic gonder0(input logic [UW-1:0] k, input logic [VW-1:0] a,
                           input logic [VW-1:0] b, input logic [EW-1:0] e);
        sur0(k, a, b, e);
        gecerli0 = 1'b1;
        @(negedge clk);
        gecerli0 = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bosta_girisler();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; gecerli0 = 1'b1; gecerli1 = 1'b1; sonuc_hazir = 1'b1;
        sur0(UOP_ADD, 32'd1, 32'd1, 4'd1);
        sur1(UOP_ADD, 32'd2, 32'd2, 4'd2);
        @(posedge clk);
        @(negedge clk);
        dogrulama++;
        if (hazir0 !== 1'b0 || hazir1 !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL reset_hazir: got %b%b expected 00", hazir0, hazir1);
        end
        dogrulama++;
        if (amb_kod_gecerli !== 1'b0 || sonuc_gecerli !== 1'b0 || sonuc_hata !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL reset_gecerli: got kg=%b sg=%b h=%b expected 0 0 0",
                     amb_kod_gecerli, sonuc_gecerli, sonuc_hata);
        end
        dogrulama++;
        if (amb_kod !== '0 || amb_a !== '0 || amb_b !== '0 || sonuc !== '0 ||
            sonuc_etiket !== '0 || sonuc_istekci !== 1'b0 || durum !== BOSTA) begin
            hata_sayisi++;
            $display("FAIL reset_veri: got kod=%0d a=%0d b=%0d s=%0d et=%0d id=%b d=%0d expected all 0",
                     amb_kod, amb_a, amb_b, sonuc, sonuc_etiket, sonuc_istekci, durum);
        end

        // reset in the middle of a long operation
        rst = 1'b0; gecerli1 = 1'b0; sonuc_hazir = 1'b0;
        gonder0(UOP_DIVU, 32'd100, 32'd7, 4'd5);
        repeat (3) @(negedge clk);
        dogrulama++;
        if (amb_kod_gecerli !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL reset_on_mesgul: got kg=%b expected 1", amb_kod_gecerli);
        end
        rst = 1'b1;
        @(negedge clk);
        dogrulama++;
        if (amb_kod_gecerli !== 1'b0 || amb_a !== '0 || amb_kod !== '0 || durum !== BOSTA) begin
            hata_sayisi++;
            $display("FAIL reset_mid_op: got kg=%b a=%0d kod=%0d d=%0d expected 0 0 0 0",
                     amb_kod_gecerli, amb_a, amb_kod, durum);
        end
        rst = 1'b0;
        // son pointer back to 1: requester 0 must win a tie
        gecerli0 = 1'b1; gecerli1 = 1'b1;
        #1;
        dogrulama++;
        if (hazir0 !== 1'b1 || hazir1 !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL reset_son: got hazir0=%b hazir1=%b expected 1 0", hazir0, hazir1);
        end
        gecerli0 = 1'b0; gecerli1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        sur0(UOP_ADD, 32'd5, 32'd7, 4'd3);
        gecerli0 = 1'b1;
        #1;
        dogrulama++;
        if (hazir0 !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL add_kabul: got hazir0=%b expected 1", hazir0);
        end
        @(negedge clk);
        gecerli0 = 1'b0;
        dogrulama++;
        if (amb_kod_gecerli !== 1'b1 || amb_kod !== UOP_ADD || amb_a !== 32'd5 ||
            amb_b !== 32'd7 || sonuc_gecerli !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL add_alu: got kg=%b kod=%0d a=%0d b=%0d sg=%b expected 1 0 5 7 0",
                     amb_kod_gecerli, amb_kod, amb_a, amb_b, sonuc_gecerli);
        end
        @(negedge clk);
        dogrulama++;
        if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd12 || sonuc_etiket !== 4'd3 ||
            sonuc_istekci !== 1'b0 || sonuc_hata !== 1'b0 || amb_kod_gecerli !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL add_sonuc: got sg=%b s=%0d et=%0d id=%b h=%b kg=%b expected 1 12 3 0 0 0",
                     sonuc_gecerli, sonuc, sonuc_etiket, sonuc_istekci, sonuc_hata, amb_kod_gecerli);
        end
        sonuc_hazir = 1'b1;
        @(negedge clk);
        sonuc_hazir = 1'b0;
        dogrulama++;
        if (sonuc_gecerli !== 1'b0 || durum !== BOSTA) begin
            hata_sayisi++;
            $display("FAIL add_bosta: got sg=%b d=%0d expected 0 0", sonuc_gecerli, durum);
        end
    endtask

    task automatic test_contention();
        logic [VW-1:0] exp_s [4];
        int k;
        int son_dongu;
        bit bitti;
        exp_s = '{32'd30, 32'd300, 32'd30, 32'd300};
        reset_dut();
        sur0(UOP_ADD, 32'd10, 32'd20, 4'd1);
        sur1(UOP_ADD, 32'd100, 32'd200, 4'd2);
        gecerli0 = 1'b1; gecerli1 = 1'b1; sonuc_hazir = 1'b1;
        #1;
        dogrulama++;
        if (hazir0 !== 1'b1 || hazir1 !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL rr_ilk: got hazir0=%b hazir1=%b expected 1 0", hazir0, hazir1);
        end
        k = 0;
        son_dongu = 0;
        for (int c = 1; c <= 12 && k < 4; c++) begin
            @(negedge clk);
            if (sonuc_gecerli) begin
                dogrulama++;
                if (sonuc !== exp_s[k] || sonuc_istekci !== logic'(k & 1)) begin
                    hata_sayisi++;
                    $display("FAIL rr_sonuc%0d: got s=%0d id=%b expected %0d %0d",
                             k, sonuc, sonuc_istekci, exp_s[k], k & 1);
                end
                if (k > 0) begin
                    dogrulama++;
                    if (c - son_dongu != 2) begin
                        hata_sayisi++;
                        $display("FAIL rr_aralik%0d: got %0d cycles expected 2", k, c - son_dongu);
                    end
                end
                son_dongu = c;
                k++;
            end
        end
        dogrulama++;
        if (k != 4) begin
            hata_sayisi++;
            $display("FAIL rr_sayi: got %0d results expected 4", k);
        end
        // drain
        gecerli0 = 1'b0; gecerli1 = 1'b0;
        bitti = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (durum == BOSTA && !sonuc_gecerli) begin
                bitti = 1'b1;
                break;
            end
        end
        sonuc_hazir = 1'b0;
        dogrulama++;
        if (!bitti) begin
            hata_sayisi++;
            $display("FAIL rr_bosalt: got d=%0d expected %0d", durum, BOSTA);
        end
    endtask

    task automatic test_multicycle();
        int mesgul;
        bit kararli;
        bit bitti;
        gonder0(UOP_DIVU, 32'd100, 32'd7, 4'd5);
        sur0(UOP_SUB, 32'hDEAD, 32'hBEEF, 4'd0);
        mesgul = 0; kararli = 1'b1; bitti = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sonuc_gecerli) begin
                bitti = 1'b1;
                break;
            end
            if (!(amb_kod_gecerli === 1'b1 && amb_kod === UOP_DIVU &&
                  amb_a === 32'd100 && amb_b === 32'd7))
                kararli = 1'b0;
            mesgul++;
            @(negedge clk);
        end
        dogrulama++;
        if (!bitti || mesgul != 33) begin
            hata_sayisi++;
            $display("FAIL divu_sure: got bitti=%b busy=%0d expected 1 33", bitti, mesgul);
        end
        dogrulama++;
        if (!kararli) begin
            hata_sayisi++;
            $display("FAIL divu_kararli: got unstable ALU inputs expected stable");
        end
        dogrulama++;
        if (sonuc !== 32'd14 || sonuc_etiket !== 4'd5 || amb_kod_gecerli !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL divu_sonuc: got s=%0d et=%0d kg=%b expected 14 5 0",
                     sonuc, sonuc_etiket, amb_kod_gecerli);
        end
        sonuc_hazir = 1'b1;
        @(negedge clk);
        sonuc_hazir = 1'b0;
    endtask

    task automatic test_backpressure();
        bit tut_ok;
        bit bitti;
        gonder0(UOP_ADD, 32'd2, 32'd3, 4'd7);
        bitti = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (sonuc_gecerli) begin
                bitti = 1'b1;
                break;
            end
            @(negedge clk);
        end
        dogrulama++;
        if (!bitti) begin
            hata_sayisi++;
            $display("FAIL bp_sonuc_yok: got sg=%b expected 1", sonuc_gecerli);
        end
        sur1(UOP_ADD, 32'd4, 32'd4, 4'd9);
        gecerli1 = 1'b1;
        tut_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!(sonuc_gecerli === 1'b1 && sonuc === 32'd5 && sonuc_etiket === 4'd7 &&
                  sonuc_istekci === 1'b0 && hazir1 === 1'b0 && hazir0 === 1'b0))
                tut_ok = 1'b0;
            @(negedge clk);
        end
        dogrulama++;
        if (!tut_ok) begin
            hata_sayisi++;
            $display("FAIL bp_tut: got s=%0d hazir1=%b expected held 5 and hazir1 0", sonuc, hazir1);
        end
        sonuc_hazir = 1'b1;
        #1;
        dogrulama++;
        if (hazir1 !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL bp_bypass_kabul: got hazir1=%b expected 1", hazir1);
        end
        @(negedge clk);
        gecerli1 = 1'b0; sonuc_hazir = 1'b0;
        dogrulama++;
        if (durum !== MESGUL || amb_kod_gecerli !== 1'b1 || amb_a !== 32'd4) begin
            hata_sayisi++;
            $display("FAIL bp_mesgul: got d=%0d kg=%b a=%0d expected %0d 1 4",
                     durum, amb_kod_gecerli, amb_a, MESGUL);
        end
        @(negedge clk);
        dogrulama++;
        if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd8 || sonuc_istekci !== 1'b1 ||
            sonuc_etiket !== 4'd9) begin
            hata_sayisi++;
            $display("FAIL bp_ikinci: got sg=%b s=%0d id=%b et=%0d expected 1 8 1 9",
                     sonuc_gecerli, sonuc, sonuc_istekci, sonuc_etiket);
        end
        sonuc_hazir = 1'b1;
        @(negedge clk);
        sonuc_hazir = 1'b0;
    endtask

    task automatic test_flush();
        bit sizinti;
        // flush while a MUL is in flight
        gonder0(UOP_MUL, 32'd6, 32'd7, 4'd1);
        dogrulama++;
        if (amb_kod_gecerli !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL flush_mul_basla: got kg=%b expected 1", amb_kod_gecerli);
        end
        @(negedge clk);
        temizle = 1'b1;
        @(negedge clk);
        temizle = 1'b0;
        dogrulama++;
        if (durum !== BOSTA || amb_kod_gecerli !== 1'b0 || sonuc_gecerli !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL flush_mesgul: got d=%0d kg=%b sg=%b expected 0 0 0",
                     durum, amb_kod_gecerli, sonuc_gecerli);
        end
        sonuc_hazir = 1'b1;
        sizinti = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sonuc_gecerli !== 1'b0) sizinti = 1'b1;
        end
        sonuc_hazir = 1'b0;
        dogrulama++;
        if (sizinti) begin
            hata_sayisi++;
            $display("FAIL flush_sonuc_yok: got a result after flush expected none");
        end

        // flush while a result is pending; also blocks a new accept
        gonder0(UOP_ADD, 32'd3, 32'd3, 4'd2);
        @(negedge clk);
        dogrulama++;
        if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd6) begin
            hata_sayisi++;
            $display("FAIL flush_cikis_once: got sg=%b s=%0d expected 1 6", sonuc_gecerli, sonuc);
        end
        sur1(UOP_ADD, 32'd9, 32'd9, 4'd4);
        temizle = 1'b1; gecerli1 = 1'b1; sonuc_hazir = 1'b1;
        #1;
        dogrulama++;
        if (hazir1 !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL flush_kabul_yok: got hazir1=%b expected 0", hazir1);
        end
        @(negedge clk);
        temizle = 1'b0; gecerli1 = 1'b0; sonuc_hazir = 1'b0;
        dogrulama++;
        if (sonuc_gecerli !== 1'b0 || durum !== BOSTA) begin
            hata_sayisi++;
            $display("FAIL flush_cikis: got sg=%b d=%0d expected 0 0", sonuc_gecerli, durum);
        end

        // normal operation afterwards
        gonder0(UOP_ADD, 32'd1, 32'd1, 4'd6);
        @(negedge clk);
        dogrulama++;
        if (sonuc_gecerli !== 1'b1 || sonuc !== 32'd2 || sonuc_etiket !== 4'd6) begin
            hata_sayisi++;
            $display("FAIL flush_sonra_add: got sg=%b s=%0d et=%0d expected 1 2 6",
                     sonuc_gecerli, sonuc, sonuc_etiket);
        end
        sonuc_hazir = 1'b1;
        @(negedge clk);
        sonuc_hazir = 1'b0;
    endtask

`ifdef AMB_HAKEM_ZAMAN_ASIMI_EN
    task automatic test_watchdog();
        int mesgul;
        alu_sessiz = 1'b1;
        gonder0(UOP_MUL, 32'd2, 32'd2, 4'd3);
        mesgul = 0;
        for (int c = 0; c < 20; c++) begin
            if (sonuc_gecerli) break;
            mesgul++;
            @(negedge clk);
        end
        dogrulama++;
        if (mesgul != 8 || sonuc !== 32'hFFFF_FFFF || sonuc_hata !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL watchdog: got busy=%0d s=%h h=%b expected 8 ffffffff 1",
                     mesgul, sonuc, sonuc_hata);
        end
        sonuc_hazir = 1'b1;
        @(negedge clk);
        sonuc_hazir = 1'b0;
        alu_sessiz = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        dogrulama   = 0;
        hata_sayisi = 0;
        alu_sessiz  = 1'b0;
        sur0(UOP_ADD, '0, '0, '0);
        sur1(UOP_ADD, '0, '0, '0);
        reset_dut();
        test_reset();
        test_single_add();
        test_contention();
        test_multicycle();
        test_backpressure();
        test_flush();
`ifdef AMB_HAKEM_ZAMAN_ASIMI_EN
        test_watchdog();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", dogrulama, hata_sayisi);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL zaman_asimi: bench did not finish within 100000 time units");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/amb_hakem.md
# amb_hakem

Two-requester arbiter and sequencer in front of the shared `amb` ALU. It accepts operations from two issue ports, round-robin arbitrates between them, and latches operands. It holds `amb_kod_gecerli_o` stable for however many cycles the multi-cycle MUL/DIV/REM/CNTZ/CNTP/HMDST paths need, then returns the tagged result through a valid/ready output port.

## Interface
Parameters:
- `VERI_BIT`, 32, operand/result width
- `UOP_BIT`, `` `UOP_AMB_BIT ``, micro-op code width
- `ETIKET_BIT`, 4, requester tag width
- `ZAMAN_SINIR`, 64, watchdog limit in cycles; used only with `AMB_HAKEM_ZAMAN_ASIMI_EN`

Ports (x = 0, 1):
- `clk_i`  in  1  single clock, all logic on the rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `temizle_i`  in  1  pipeline flush; drops the in-flight or pending result
- `istekx_gecerli_i`  in  1  requester x has an operation
- `istekx_hazir_o`  out  1  requester x is accepted this cycle
- `istekx_kod_i`  in  UOP_BIT  micro-op code
- `istekx_islec1_i`, `istekx_islec2_i`  in  VERI_BIT  operands
- `istekx_etiket_i`  in  ETIKET_BIT  tag, returned with the result
- `amb_kod_o`  out  UOP_BIT  code to the ALU
- `amb_kod_gecerli_o`  out  1  ALU operation valid
- `amb_islec1_o`, `amb_islec2_o`  out  VERI_BIT  latched operands
- `amb_sonuc_i`  in  VERI_BIT  ALU result
- `amb_gecerli_i`  in  1  ALU result valid
- `sonuc_gecerli_o`  out  1  result available
- `sonuc_hazir_i`  in  1  consumer takes the result
- `sonuc_o`  out  VERI_BIT  result
- `sonuc_istekci_o`  out  1  requester id of the result
- `sonuc_etiket_o`  out  ETIKET_BIT  tag of the result
- `sonuc_hata_o`  out  1  watchdog abort flag

## Operation
The controller has three states: BOSTA, MESGUL and CIKIS.

- **BOSTA (idle):**
  - `istekx_hazir_o` = `istekx_gecerli_i` & grant_x & !`temizle_i`.
  - On a handshake, latch code, operands, tag and requester id, then go to MESGUL.
- **MESGUL (busy):**
  - Drive `amb_kod_gecerli_o` = 1 with the latched code and operands, all held constant.
  - On `amb_gecerli_i`, capture `amb_sonuc_i` into the output register and go to CIKIS.
- **CIKIS (output):**
  - `sonuc_gecerli_o` = 1 and `amb_kod_gecerli_o` = 0. The 0 guarantees the ALU counter and accumulator clear between operations.
  - On `sonuc_hazir_i`, go to BOSTA. If a request is also granted in the same cycle, accept it and go straight to MESGUL.
  - `istekx_hazir_o` in CIKIS = grant_x & `istekx_gecerli_i` & `sonuc_hazir_i` & !`temizle_i`.
- **Arbitration:**
  - Round-robin on the `son` pointer (last granted requester).
  - With both requesters valid, the grant goes to !`son`. With one valid, it goes to that one.
  - `son` updates only on an accepted handshake. Reset value of `son` = 1, so requester 0 wins first.
- **Flush (`temizle_i`):**
  - From any state, the next state is BOSTA. No request is accepted in that cycle.
  - `amb_kod_gecerli_o` and `sonuc_gecerli_o` are 0 from the next cycle on. A pending result is discarded.
  - Flush has priority over `amb_gecerli_i` and over `sonuc_hazir_i`.
- **Output stability:** outputs hold constant while `sonuc_gecerli_o` = 1 and `sonuc_hazir_i` = 0.

## Timing
- Reset values:
  - state = BOSTA, `son` = 1
  - all `*_hazir_o` = 0 while `rst_i` = 1
  - `amb_kod_gecerli_o` = 0, `sonuc_gecerli_o` = 0, `sonuc_hata_o` = 0
  - `amb_*` data outputs, `sonuc_o`, `sonuc_etiket_o` and `sonuc_istekci_o` all 0
- Accept at cycle N drives the ALU at N+1.
- A single-cycle op (`amb_gecerli_i` at N+1) gives `sonuc_gecerli_o` at N+2.
- A k-cycle ALU op gives `sonuc_gecerli_o` at N+1+k.
- Minimum issue interval is 2 cycles, using the CIKIS→MESGUL bypass.
- Reset asserted mid-operation returns every register to its reset value at the next edge. The ALU sees `amb_kod_gecerli_o` = 0.

## Configuration
- `AMB_HAKEM_ZAMAN_ASIMI_EN` defined:
  - A counter clears on entry to MESGUL and increments each MESGUL cycle.
  - When it reaches `ZAMAN_SINIR` without `amb_gecerli_i`, the controller goes to CIKIS with `sonuc_o` = all ones and `sonuc_hata_o` = 1.
  - `amb_kod_gecerli_o` drops in that same transition.
  - `sonuc_hata_o` = 0 for normal results.
- Not defined: no counter, MESGUL waits indefinitely, and `sonuc_hata_o` is tied to 0.

## Structure
- Shared header `amb_hakem.vh`: state encodings (BOSTA, MESGUL, CIKIS) and requester ids (`ISTEKCI_0`, `ISTEKCI_1`).
- Shared constants are reused from `sabitler.vh`.
- Sub-module `rr_hakem2`: combinational 2-way round-robin grant from the two valid bits and `son`.
- `son` itself is a register in `amb_hakem`.

## Test plan
- **Single ADD:** requester 0 sends ADD 5, 7 with tag 3 at cycle 1. Expect `sonuc_gecerli_o` at cycle 3 with `sonuc_o` = 12, `sonuc_etiket_o` = 3, `sonuc_istekci_o` = 0.
- **Contention:** both requesters valid continuously with ADDs. Grants alternate 0, 1, 0, 1; results come one every 2 cycles with `sonuc_hazir_i` = 1.
- **Multi-cycle op:** DIVU 100, 7 against an ALU model with a 33-cycle divider. `amb_kod_gecerli_o` stays 1 with stable operands until completion. Result = 14, and `amb_kod_gecerli_o` = 0 the cycle after.
- **Backpressure:** `sonuc_hazir_i` = 0 for 10 cycles while requester 1 is valid. The result holds, `istek1_hazir_o` stays 0, and requester 1 is accepted in the same cycle `sonuc_hazir_i` rises.
- **Flush:** `temizle_i` pulses mid-MUL. Next cycle: BOSTA, `amb_kod_gecerli_o` = 0, and no result is emitted. A later ADD 1, 1 gives 2.
- **Watchdog** (`AMB_HAKEM_ZAMAN_ASIMI_EN`, `ZAMAN_SINIR` = 8): `amb_gecerli_i` is held 0. After 8 MESGUL cycles, `sonuc_o` = 0xFFFFFFFF and `sonuc_hata_o` = 1.
